// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types and constants for the two-digit display scanner
//
// Purpose : converter state encoding, display range and digit width used by
//           disp_scan_ctrl and its bench.
// Contents: state_t (ST_IDLE, ST_CONV), DISP_MAX, RADIX, DIG_W.
package disp_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_CONV = 1'b1
   } state_t;

   localparam int DISP_MAX = 99;
   localparam int RADIX    = 10;
   localparam int DIG_W    = 4;

endpackage

// File: rtl/refresh_tick.sv
// rtl/refresh_tick.sv - free-running modulo-DIV counter with terminal-count tick
//
// Purpose : paces the digit scan; TICK is high for exactly one cycle out of
//           every DIV cycles.
// Ports   : CLK   in  rising-edge clock
//           RST_N in  asynchronous active-low reset (counter cleared to 0)
//           TICK  out high while the counter sits at DIV-1
module refresh_tick #(
   parameter int DIV = 100000,
   parameter int W   = 17
) (
   input  logic CLK,
   input  logic RST_N,
   output logic TICK
);

   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt;

   // With DIV=1 the counter never leaves 0, so TICK stays high every cycle.
   assign TICK = (cnt == LAST);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt <= '0;
      end else if (TICK) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - binary-to-two-digit converter and digit scan driver
//
// Purpose : splits a loaded binary value 0..99 into tens/ones digits by
//           repeated subtraction of 10, then time-multiplexes the two digits
//           onto one 4-bit bus with a digit-select line.
// Ports   : CLK   in  rising-edge clock
//           RST_N in  asynchronous active-low reset
//           VALUE in  [6:0] value to display
//           LOAD  in  one-cycle load strobe, honoured only when BUSY=0
//           BUSY  out conversion in progress
//           OVF   out sticky: last accepted LOAD carried VALUE > 99
//           DIGIT out [3:0] digit code for the current slot
//           CA    out digit select, 0 = ones slot, 1 = tens slot
//           BLANK out current slot should be dark (leading zero)
module disp_scan_ctrl
   import disp_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int CNT_W       = 17,
   parameter int BLANK_LZ    = 1
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [6:0]       VALUE,
   input  logic             LOAD,
   output logic             BUSY,
   output logic             OVF,
   output logic [DIG_W-1:0] DIGIT,
   output logic             CA,
   output logic             BLANK
);

   state_t           state, state_next;
   logic [6:0]       rem, rem_next;
   logic [DIG_W-1:0] tens_acc, tens_acc_next;
   logic [DIG_W-1:0] tens_q, ones_q;
   logic             ovf_next;
   logic             commit;
   logic             tick;
   logic             ca_next;

   refresh_tick #(
      .DIV (REFRESH_DIV),
      .W   (CNT_W)
   ) u_refresh_tick (
      .CLK   (CLK),
      .RST_N (RST_N),
      .TICK  (tick)
   );

   always_comb begin
      state_next    = state;
      rem_next      = rem;
      tens_acc_next = tens_acc;
      ovf_next      = OVF;
      commit        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (LOAD) begin
               if (VALUE > 7'(DISP_MAX)) begin
                  // Out-of-range value: flag it but keep showing the old digits.
                  ovf_next = 1'b1;
               end else begin
                  rem_next      = VALUE;
                  tens_acc_next = '0;
                  ovf_next      = 1'b0;
                  state_next    = ST_CONV;
               end
            end
         end
         ST_CONV: begin
            if (rem >= 7'(RADIX)) begin
               rem_next      = rem - 7'(RADIX);
               tens_acc_next = tens_acc + DIG_W'(1);
            end else begin
               commit     = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign ca_next = tick ? ~CA : CA;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= ST_IDLE;
         rem      <= '0;
         tens_acc <= '0;
         tens_q   <= '0;
         ones_q   <= '0;
         BUSY     <= 1'b0;
         OVF      <= 1'b0;
         CA       <= 1'b0;
         DIGIT    <= '0;
         BLANK    <= 1'b0;
      end else begin
         state    <= state_next;
         rem      <= rem_next;
         tens_acc <= tens_acc_next;
         OVF      <= ovf_next;
         BUSY     <= (state_next == ST_CONV);
         // Both digits change on one edge so the scan never mixes old and new.
         if (commit) begin
            tens_q <= tens_acc;
            ones_q <= rem[DIG_W-1:0];
         end
         // DIGIT/BLANK follow the slot CA is entering and refresh every cycle,
         // so a commit shows up one edge later without waiting for a slot change.
         CA    <= ca_next;
         DIGIT <= ca_next ? tens_q : ones_q;
         BLANK <= (BLANK_LZ != 0) && ca_next && (tens_q == '0);
      end
   end

endmodule
